el2_dec_gpr_wb_arb: RTL
=======================

# el2_dec_gpr_wb_arb

Writeback arbiter for the integer register file. It accepts GPR write requests from up to `NREQ` writeback sources, such as the pipe, divider, non-blocking load return and debug, and schedules them onto the register file's three write ports. Scheduling is round-robin and never places two writes to the same register in one cycle. It sits in the decode unit between the writeback sources and the GPR file, and drives that file's `wenN`/`waddrN`/`wdN` inputs from registers.

## Interface
- `NREQ`, default 4: number of requesters, legal range 2–8.
- `clk`  in  1: core clock.
- `rst`  in  1: reset. One clock; reset is synchronous and active-high.
- `req_valid`  in  `[NREQ-1:0]`: request pending, one bit per requester.
- `req_addr`  in  `[NREQ-1:0][4:0]`: destination GPR.
- `req_data`  in  `[NREQ-1:0][31:0]`: write data.
- `req_ready`  out  `[NREQ-1:0]`: combinational accept, valid in the same cycle.
- `wen0`/`wen1`/`wen2`  out  1 each: registered write enables to the GPR file.
- `waddr0`/`waddr1`/`waddr2`  out  5 each: registered write addresses.
- `wd0`/`wd1`/`wd2`  out  32 each: registered write data.
- `stall_cnt`  out  `[NREQ-1:0][15:0]`: present only with the stats macro defined (see Configuration).

## Operation
- **Handshake.** A requester holds `req_valid`, `req_addr` and `req_data` stable until it sees `req_ready`=1. A transfer completes when valid and ready are both 1.
- **Scan order.** Each cycle the arbiter scans requesters in rotated order `rr_ptr`, `rr_ptr+1`, … (mod `NREQ`).
- **x0 requests.** A valid request with `req_addr`=0 is accepted immediately. It consumes no port and generates no write. It does not move `rr_ptr`.
- **Granting.** A valid request with nonzero `req_addr` is granted only if both conditions hold:
  - fewer than 3 ports are already allocated this cycle;
  - its address differs from every address already granted this cycle.
- **Port assignment.** Granted requests take ports in scan order: first grant on port 0, second on port 1, third on port 2.
- **Same-address conflict.** The requester later in scan order gets `req_ready`=0 and retries the next cycle. This preserves write-after-write order for the requester that was not yet served.
- **Pointer update.** `rr_ptr` moves to (index of the last nonzero-address grant + 1) mod `NREQ`. If there was no such grant, it is unchanged.
- **Fairness.** A continuously valid requester is granted within `NREQ` cycles.
- **Unused ports.** A port with no grant drives `wenN`=0, `waddrN`=0, `wdN`=0.
- The arbiter has no internal request buffer. Its only state is `rr_ptr`, the output registers and the optional counters.

## Timing
- Latency is 1 cycle: a grant in cycle N produces `wenN`/`waddrN`/`wdN` in cycle N+1.
- `req_ready` is combinational from `req_valid`, `req_addr` and `rr_ptr`. It has no combinational path from `req_data`.
- Full throughput is 3 writes per cycle with no bubbles.
- **Reset values.** All `wen*`, `waddr*`, `wd*`, `rr_ptr` and `stall_cnt` are 0.
- **Behaviour around reset.**
  - While `rst` is high, `req_ready` is 0.
  - Reset asserted mid-operation clears outputs on the next edge, and no in-flight write is emitted.
  - A request pending across reset is re-arbitrated after `rst` drops.
- **Pointer wrap.** `rr_ptr` wraps from `NREQ-1` to 0.
- **Guaranteed output property.** The three `wen` ports never carry equal nonzero `waddr` in the same cycle, which satisfies the GPR file's write-collision assertion.

## Configuration
- Macro `RV_GPR_WB_ARB_STATS_EN`.
- **Defined:**
  - the `stall_cnt` port exists;
  - per requester, the counter increments each cycle in which `req_valid`=1 and `req_ready`=0;
  - it saturates at 16'hFFFF;
  - it clears on `rst`.
- **Undefined:** no counter logic and no `stall_cnt` port. Arbitration behaviour is identical.

## Structure
- **Shared package `el2_pkg`:**
  - `localparam EL2_GPR_WB_NPORTS = 3`;
  - `typedef el2_gpr_wb_req_t`, with fields `valid`, `addr[4:0]`, `data[31:0]`.
- **Sub-module `el2_rr_pick`:**
  - inputs: a request mask and a pointer;
  - outputs: one-hot first set bit at or after the pointer, plus a found flag;
  - instantiated 3 times in a chain. Each stage masks out already-picked requesters and requesters whose address matches an earlier pick.
  - x0 acceptance is handled outside the chain.

## Test plan
- **Oversubscription.**
  - Stimulus: `NREQ`=4, `rr_ptr`=0, all valid with addresses 5, 6, 7, 8.
  - Cycle 1: `req_ready`=4'b0111.
  - Cycle 2: ports 0/1/2 write 5/6/7 and `rr_ptr`=3.
  - Then req3 is granted on port 0, writing 8.
- **Address collision.**
  - Stimulus: req0 and req1 both to x9, data A/B.
  - `req_ready`=4'b0001, then x9=A written.
  - Next cycle: req1 granted, then x9=B written. No cycle has a duplicate `waddr`.
- **x0 request.**
  - Stimulus: req2 alone, address 0.
  - `req_ready`=4'b0100. All `wen` are 0 on the next cycle. `rr_ptr` is unchanged.
- **Reset mid-operation.**
  - Stimulus: `rst`=1 in the cycle after `wen0`=1 with `waddr0`=3.
  - Next edge: all outputs 0 and `rr_ptr`=0. `req_ready` is 0 while reset is held.
- **Sustained throughput.**
  - Stimulus: req0–req2 valid for 10 cycles with distinct nonzero addresses.
  - Exactly 30 writes, 3 per cycle, with no bubble.
- **Stats (`RV_GPR_WB_ARB_STATS_EN`).**
  - Stimulus: req1 blocked by collision for 3 cycles.
  - `stall_cnt[1]`=3.
  - With the counter forced to 16'hFFFE and 2 further stalls, it holds at 16'hFFFF.

Source files
------------

// File: rtl/el2_pkg.sv
// Shared decode-unit types: GPR writeback port count and request bundle.
package el2_pkg;

  localparam int EL2_GPR_WB_NPORTS = 3;

  typedef struct packed {
    logic        valid;
    logic [4:0]  addr;
    logic [31:0] data;
  } el2_gpr_wb_req_t;

endpackage

// File: rtl/el2_rr_pick.sv
// Round-robin picker: one-hot first set mask bit at or after the pointer.
module el2_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_mask,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic          o_found
);

  logic [2*N-1:0] w_dbl;

  // Lower copy holds indices >= ptr, upper copy supplies the wrapped tail.
  always_comb begin
    w_dbl = {i_mask, i_mask};
    for (int j = 0; j < N; j++) begin
      if (j < int'(i_ptr)) w_dbl[j] = 1'b0;
    end
    o_onehot = '0;
    o_found  = 1'b0;
    for (int j = 0; j < 2*N; j++) begin
      if (!o_found && w_dbl[j]) begin
        o_onehot[j%N] = 1'b1;
        o_found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/el2_dec_gpr_wb_arb.sv
// GPR writeback arbiter: round-robin onto 3 registered write ports.
// Optional per-requester stall counters: RV_GPR_WB_ARB_STATS_EN.
module el2_dec_gpr_wb_arb
  import el2_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0][4:0]   req_addr,
  input  logic [NREQ-1:0][31:0]  req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   wen0,
  output logic                   wen1,
  output logic                   wen2,
  output logic [4:0]             waddr0,
  output logic [4:0]             waddr1,
  output logic [4:0]             waddr2,
  output logic [31:0]            wd0,
  output logic [31:0]            wd1,
  output logic [31:0]            wd2
`ifdef RV_GPR_WB_ARB_STATS_EN
  ,
  output logic [NREQ-1:0][15:0]  stall_cnt
`endif
);

  localparam int NP = EL2_GPR_WB_NPORTS;
  localparam int PW = $clog2(NREQ);

  el2_gpr_wb_req_t           w_req [NREQ];
  logic [NREQ-1:0]           w_nz;
  logic [NREQ-1:0]           w_x0;
  logic [NREQ-1:0]           w_gnt;
  logic [NREQ-1:0]           w_lastpick;
  logic [NP-1:0][NREQ-1:0]   w_mask;
  logic [NP-1:0][NREQ-1:0]   w_pick;
  logic [NP-1:0]             w_found;
  logic [NP-1:0][4:0]        w_paddr;
  logic [NP-1:0][31:0]       w_pdata;
  logic [PW-1:0]             w_last_idx;
  logic [PW-1:0]             w_ptr_nxt;

  logic [PW-1:0]             r_rr_ptr;
  logic [NP-1:0]             r_wen;
  logic [NP-1:0][4:0]        r_waddr;
  logic [NP-1:0][31:0]       r_wd;

  function automatic logic [NREQ-1:0] f_match(
    input logic [NREQ-1:0][4:0] a,
    input logic [4:0]           x
  );
    logic [NREQ-1:0] m;
    m = '0;
    for (int i = 0; i < NREQ; i++) m[i] = (a[i] == x);
    return m;
  endfunction

  always_comb begin
    w_nz = '0;
    w_x0 = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_req[i] = '{valid: req_valid[i],
                   addr:  req_addr[i],
                   data:  req_data[i]};
      w_nz[i]  = w_req[i].valid && (w_req[i].addr != 5'd0);
      w_x0[i]  = w_req[i].valid && (w_req[i].addr == 5'd0);
    end
  end

  assign w_mask[0] = w_nz;

  // Each stage drops earlier picks and anything aliasing their address.
  for (genvar s = 0; s < NP; s++) begin : g_stage
    el2_rr_pick #(
      .N  (NREQ),
      .PW (PW)
    ) u_pick (
      .i_mask   (w_mask[s]),
      .i_ptr    (r_rr_ptr),
      .o_onehot (w_pick[s]),
      .o_found  (w_found[s])
    );

    always_comb begin
      w_paddr[s] = '0;
      w_pdata[s] = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (w_pick[s][i]) begin
          w_paddr[s] = w_paddr[s] | w_req[i].addr;
          w_pdata[s] = w_pdata[s] | w_req[i].data;
        end
      end
    end

    if (s < NP-1) begin : g_nxt
      assign w_mask[s+1] = w_mask[s] & ~w_pick[s]
                         & ~f_match(req_addr, w_paddr[s]);
    end
  end

  always_comb begin
    w_gnt = '0;
    for (int s = 0; s < NP; s++) w_gnt = w_gnt | w_pick[s];
  end

  assign req_ready = rst ? '0 : (w_x0 | w_gnt);

  always_comb begin
    if (w_found[2])      w_lastpick = w_pick[2];
    else if (w_found[1]) w_lastpick = w_pick[1];
    else                 w_lastpick = w_pick[0];
    w_last_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_lastpick[i]) w_last_idx = PW'(i);
    end
    if (!w_found[0])
      w_ptr_nxt = r_rr_ptr;
    else if (w_last_idx == PW'(NREQ-1))
      w_ptr_nxt = '0;
    else
      w_ptr_nxt = w_last_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_wen    <= '0;
      r_waddr  <= '0;
      r_wd     <= '0;
    end else begin
      r_rr_ptr <= w_ptr_nxt;
      r_wen    <= w_found;
      r_waddr  <= w_paddr;
      r_wd     <= w_pdata;
    end
  end

  assign wen0   = r_wen[0];
  assign wen1   = r_wen[1];
  assign wen2   = r_wen[2];
  assign waddr0 = r_waddr[0];
  assign waddr1 = r_waddr[1];
  assign waddr2 = r_waddr[2];
  assign wd0    = r_wd[0];
  assign wd1    = r_wd[1];
  assign wd2    = r_wd[2];

`ifdef RV_GPR_WB_ARB_STATS_EN
  logic [NREQ-1:0][15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && !req_ready[i] &&
            r_stall_cnt[i] != 16'hFFFF)
          r_stall_cnt[i] <= r_stall_cnt[i] + 16'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
